instr_sequencer: RTL and testbench

Program sequencer for the TinyALU CPU. It owns the program counter and fetches 19-bit instructions from a synchronous instruction memory. It presents each instruction to instructionUnit and holds it stable until the unit reports done, then advances. It adds run/abort control, a per-instruction watchdog and status outputs.

---
 rtl/tinyalu_pkg.sv | 29 ++
 rtl/seq_watchdog.sv | 41 ++++
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: the 19-bit instruction word layout and the sequencer state encoding.
package tinyalu_pkg;

   localparam int unsigned INSTR_W     = 19;
   localparam int unsigned OPC_MSB     = 18;
   localparam int unsigned OPC_LSB     = 15;
   localparam int unsigned ADDR_MSB    = 14;
   localparam int unsigned ADDR_LSB    = 1;
   localparam int unsigned REG_SEL_BIT = 0;
   localparam int unsigned OPC_W       = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned ADDR_W      = ADDR_MSB - ADDR_LSB + 1;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [ADDR_W-1:0] addr;
      logic              reg_sel;
   } instruction_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERROR
   } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-instruction watchdog: counts ISSUE+WAIT cycles and flags when TIMEOUT_CYCLES have elapsed.
module seq_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] elapsed;

   // elapsed includes the current cycle; clear marks the first (ISSUE) cycle
   always_comb begin
      elapsed = clear ? CNT_W'(1) : cnt_q + CNT_W'(1);
      cnt_d   = cnt_q;
      if (clear || enable) begin
         cnt_d = elapsed;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
   end else begin : g_enabled
      assign expired = (clear || enable) && (elapsed >= CNT_W'(TIMEOUT_CYCLES));
   end

endmodule

// File: rtl/instr_sequencer.sv
// TinyALU program sequencer: fetches instructions from synchronous imem, holds each one
// for instructionUnit until done, with run/abort control, watchdog and status outputs.
module instr_sequencer
   import tinyalu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH     = 1024,
   parameter int unsigned PC_W           = 10,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               abort,
   input  logic [PC_W:0]      prog_len,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_rd_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output instruction_t       instr,
   output logic               instr_valid,
   input  logic               unit_done,
   output logic               busy,
   output logic               halted,
   output logic               timeout_err,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W:0]      instr_count
);

   localparam int unsigned LEN_W = PC_W + 1;

   seq_state_t       state_q;
   logic [PC_W-1:0]  pc_q;
   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_d;
   logic [LEN_W-1:0] pc_plus1;
   instruction_t     instr_q;
   logic             halted_q;
   logic             terr_q;
   logic             busy_q;
   logic             valid_q;
   logic             last_instr;
   logic             wd_expired;

   // clamp the requested length so pc can never run past the memory
   always_comb begin
      len_d      = (prog_len > LEN_W'(IMEM_DEPTH)) ? LEN_W'(IMEM_DEPTH) : prog_len;
      pc_plus1   = LEN_W'(pc_q) + LEN_W'(1);
      last_instr = (pc_plus1 == len_q);
   end

   seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_q == S_ISSUE),
      .enable  (state_q == S_WAIT),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         count_q  <= '0;
         len_q    <= '0;
         instr_q  <= '0;
         halted_q <= 1'b0;
         terr_q   <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else if (abort) begin
         // pc, count and instr are kept for post-mortem debug
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (run) begin
                  pc_q     <= '0;
                  count_q  <= '0;
                  len_q    <= len_d;
                  terr_q   <= 1'b0;
                  halted_q <= (len_d == '0);
                  if (len_d == '0) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_FETCH;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               instr_q <= instruction_t'(imem_rdata);
               valid_q <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ISSUE, S_WAIT: begin
               // completion takes priority over a simultaneous watchdog expiry
               if (unit_done) begin
                  count_q <= count_q + LEN_W'(1);
                  if (last_instr) begin
                     state_q  <= S_DONE;
                     halted_q <= 1'b1;
                     busy_q   <= 1'b0;
                  end else begin
                     pc_q    <= pc_q + PC_W'(1);
                     state_q <= S_FETCH;
                  end
               end else if (wd_expired) begin
                  state_q <= S_ERROR;
                  terr_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_rd_en  = (state_q == S_FETCH) && !abort;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign timeout_err = terr_q;
   assign pc          = pc_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a timeline-based reference model.
module tb_instr_sequencer;
   import tinyalu_pkg::*;

   localparam int unsigned DEPTH = 12;
   localparam int unsigned PCW   = 4;
   localparam int unsigned TO    = 8;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               run;
   logic               abort;
   logic               unit_done;
   logic [PCW:0]       prog_len;
   logic [PCW-1:0]     imem_addr;
   logic               imem_rd_en;
   logic [INSTR_W-1:0] imem_rdata;
   instruction_t       instr;
   logic               instr_valid;
   logic               busy;
   logic               halted;
   logic               timeout_err;
   logic [PCW-1:0]     pc;
   logic [PCW:0]       instr_count;

   logic [INSTR_W-1:0] mem [0:15];
   logic [INSTR_W-1:0] word;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state: a run is a timeline of expected issue cycles
   int                 cyc = 0;
   int                 c_prev;
   bit                 m_on = 1'b0;
   bit                 m_run;
   int                 m_issue;
   int                 m_pc;
   int                 m_cnt;
   int                 m_len;
   bit                 m_halt;
   bit                 m_terr;
   logic [INSTR_W-1:0] m_instr;
   bit                 e_valid;
   bit                 e_rd;

   int rd_seen = 0;
   int first_v, vcnt, dly, err_at, r0, nv, nr, v0, v1, r1, mode;
   bit hit;

   always #5 clk = ~clk;

   instr_sequencer #(
      .IMEM_DEPTH     (DEPTH),
      .PC_W           (PCW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .abort       (abort),
      .prog_len    (prog_len),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .unit_done   (unit_done),
      .busy        (busy),
      .halted      (halted),
      .timeout_err (timeout_err),
      .pc          (pc),
      .instr_count (instr_count)
   );

   always @(posedge clk) begin
      if (imem_rd_en === 1'b1) imem_rdata <= mem[imem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: advances on every clock edge from the inputs the bench drove
   always @(posedge clk) begin
      c_prev = cyc;
      cyc    = cyc + 1;
      if (reset_n === 1'b0) begin
         m_on = 1'b1; m_run = 1'b0; m_issue = -10; m_pc = 0; m_cnt = 0; m_len = 0;
         m_halt = 1'b0; m_terr = 1'b0; m_instr = '0;
      end else if (abort) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (run) begin
            m_len   = (int'(prog_len) > int'(DEPTH)) ? int'(DEPTH) : int'(prog_len);
            m_pc    = 0;
            m_cnt   = 0;
            m_terr  = 1'b0;
            m_halt  = (m_len == 0);
            m_run   = (m_len != 0);
            m_issue = cyc + 2;
         end
      end else if (c_prev >= m_issue) begin
         if (unit_done) begin
            m_cnt++;
            if (m_pc + 1 == m_len) begin
               m_run  = 1'b0;
               m_halt = 1'b1;
            end else begin
               m_pc++;
               m_issue = cyc + 2;
            end
         end else if (int'(TO) != 0 && c_prev - m_issue + 1 >= int'(TO)) begin
            m_run  = 1'b0;
            m_terr = 1'b1;
         end
      end
      if (m_run && cyc == m_issue) m_instr = mem[m_pc];
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (imem_rd_en === 1'b1) rd_seen++;
      if (m_on) begin
         e_valid = m_run && (cyc == m_issue);
         e_rd    = m_run && (cyc == m_issue - 2) && !abort;
         chk("busy", 32'(busy), 32'(m_run));
         chk("instr_valid", 32'(instr_valid), 32'(e_valid));
         chk("imem_rd_en", 32'(imem_rd_en), 32'(e_rd));
         if (e_rd) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
         chk("pc", 32'(pc), 32'(m_pc));
         chk("instr_count", 32'(instr_count), 32'(m_cnt));
         chk("halted", 32'(halted), 32'(m_halt));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
         chk("instr", 32'(instr), 32'(m_instr));
      end
   end

   // run until the first WAIT cycle of instruction 'target', completing earlier ones at once
   task automatic run_to_wait(input int target, output bit got);
      bit seen;
      seen = 1'b0;
      got  = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         unit_done = (int'(pc) != target);
         @(negedge clk);
         if (instr_valid === 1'b1 && int'(pc) == target) seen = 1'b1;
         else if (seen) got = 1'b1;
         if (!got) tick();
      end
   endtask

   initial begin
      reset_n = 1'b0; run = 1'b0; abort = 1'b0; unit_done = 1'b0; prog_len = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // three-instruction program, done two cycles after each issue
      mem[0] = {4'h1, 14'h10, 1'b0};
      mem[1] = {4'h1, 14'h11, 1'b1};
      mem[2] = {4'h2, 14'h12, 1'b0};
      prog_len = 5'd3; run = 1'b1;
      tick();
      run = 1'b0;
      vcnt = 0; first_v = -1; dly = 0;
      for (int i = 0; i < 40 && !(halted === 1'b1); i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            if (first_v < 0) first_v = i;
            if (vcnt < 3) chk("prog3_instr", 32'(instr), 32'(mem[vcnt]));
            vcnt++;
            dly = 2;
         end
         tick();
         unit_done = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) unit_done = 1'b1;
         end
      end
      @(negedge clk);
      word = instr;
      chk("prog3_first_valid", 32'(first_v), 32'd2);
      chk("prog3_valids", 32'(vcnt), 32'd3);
      chk("prog3_halted", 32'(halted), 32'd1);
      chk("prog3_count", 32'(instr_count), 32'd3);
      chk("prog3_pc", 32'(pc), 32'd2);
      chk("prog3_last_opcode", 32'(word[OPC_MSB:OPC_LSB]), 32'h2);
      chk("prog3_last_addr", 32'(word[ADDR_MSB:ADDR_LSB]), 32'h12);
      chk("prog3_last_regsel", 32'(word[REG_SEL_BIT]), 32'd0);
      tick();

      // empty program: halts immediately without fetching
      r0 = rd_seen;
      prog_len = 5'd0; run = 1'b1;
      tick();
      run = 1'b0;
      @(negedge clk);
      chk("len0_halted", 32'(halted), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_count", 32'(instr_count), 32'd0);
      repeat (4) tick();
      chk("len0_no_fetch", 32'(rd_seen), 32'(r0));

      // watchdog: done never arrives
      unit_done = 1'b0;
      prog_len = 5'd2; run = 1'b1;
      tick();
      run = 1'b0;
      err_at = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (timeout_err === 1'b1 && err_at < 0) err_at = i;
         tick();
      end
      @(negedge clk);
      chk("wd_err_cycle", 32'(err_at), 32'd10);
      chk("wd_pc", 32'(pc), 32'd0);
      chk("wd_busy", 32'(busy), 32'd0);
      tick();
      prog_len = 5'd1; run = 1'b1;
      tick();
      run = 1'b0;
      @(negedge clk);
      chk("wd_restart_err", 32'(timeout_err), 32'd0);
      chk("wd_restart_pc", 32'(pc), 32'd0);
      chk("wd_restart_busy", 32'(busy), 32'd1);
      tick();
      unit_done = 1'b1;
      repeat (4) tick();
      unit_done = 1'b0;
      @(negedge clk);
      chk("wd_restart_halted", 32'(halted), 32'd1);
      chk("wd_restart_count", 32'(instr_count), 32'd1);
      tick();

      // done coincident with instr_valid: no WAIT cycle
      unit_done = 1'b1;
      prog_len = 5'd2; run = 1'b1;
      tick();
      run = 1'b0;
      nv = 0; nr = 0; v0 = -1; v1 = -1; r1 = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            if (nv == 0) v0 = i;
            else if (nv == 1) v1 = i;
            nv++;
         end
         if (imem_rd_en === 1'b1) begin
            if (nr == 1) r1 = i;
            nr++;
         end
         tick();
      end
      unit_done = 1'b0;
      @(negedge clk);
      chk("fast_v0", 32'(v0), 32'd2);
      chk("fast_fetch1", 32'(r1), 32'd3);
      chk("fast_v1", 32'(v1), 32'd5);
      chk("fast_nvalid", 32'(nv), 32'd2);
      chk("fast_count", 32'(instr_count), 32'd2);
      chk("fast_pc", 32'(pc), 32'd1);
      tick();

      // abort and run together while waiting on instruction 4
      for (int i = 0; i < 16; i++) mem[i] = INSTR_W'($urandom);
      prog_len = 5'd8; run = 1'b1;
      tick();
      run = 1'b0;
      run_to_wait(4, hit);
      chk("abort_reached_wait", 32'(hit), 32'd1);
      tick();
      abort = 1'b1; run = 1'b1; prog_len = 5'd3;
      tick();
      abort = 1'b0; run = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_pc", 32'(pc), 32'd4);
      chk("abort_instr", 32'(instr), 32'(mem[4]));
      chk("abort_count", 32'(instr_count), 32'd4);
      chk("abort_valid", 32'(instr_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("abort_stays_idle", 32'(busy), 32'd0);
      tick();
      prog_len = 5'd2; run = 1'b1;
      tick();
      run = 1'b0;
      @(negedge clk);
      chk("abort_restart_pc", 32'(pc), 32'd0);
      chk("abort_restart_count", 32'(instr_count), 32'd0);
      chk("abort_restart_busy", 32'(busy), 32'd1);
      tick();
      unit_done = 1'b1;
      repeat (10) tick();
      unit_done = 1'b0;

      // synchronous reset in the middle of WAIT at pc=5
      prog_len = 5'd8; run = 1'b1;
      tick();
      run = 1'b0;
      run_to_wait(5, hit);
      chk("reset_reached_wait", 32'(hit), 32'd1);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("wait_rst_pc", 32'(pc), 32'd0);
      chk("wait_rst_instr", 32'(instr), 32'd0);
      chk("wait_rst_busy", 32'(busy), 32'd0);
      chk("wait_rst_halted", 32'(halted), 32'd0);
      chk("wait_rst_count", 32'(instr_count), 32'd0);
      tick();

      // oversize length is clamped to the memory depth
      unit_done = 1'b1;
      prog_len = 5'd20; run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < 80 && !(halted === 1'b1); i++) tick();
      unit_done = 1'b0;
      @(negedge clk);
      chk("clamp_halted", 32'(halted), 32'd1);
      chk("clamp_count", 32'(instr_count), 32'(DEPTH));
      chk("clamp_pc", 32'(pc), 32'(DEPTH - 1));
      tick();

      // randomized traffic, checked only by the model comparison
      mode = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) mode = $urandom_range(0, 2);
         reset_n = ($urandom_range(0, 400) != 0);
         abort   = ($urandom_range(0, 50) == 0);
         run     = ($urandom_range(0, 5) == 0);
         prog_len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31))
                                                : 5'($urandom_range(0, 6));
         case (mode)
            0:       unit_done = ($urandom_range(0, 2) == 0);
            1:       unit_done = 1'b1;
            default: unit_done = 1'b0;
         endcase
         tick();
      end
      reset_n = 1'b1; abort = 1'b0; run = 1'b0; unit_done = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
